// File: rtl/mem_pkg.sv
// Shared definitions for the RAM-port requesters: FSM encoding, lane layout
// and the second-byte address incrementer (also used by the fetch unit).
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HI   = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } mem_state_t;

    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned WIDE_WIDTH     = 2 * DATA_WIDTH_DEF;
    localparam int unsigned LANE_LO        = 0;
    localparam int unsigned LANE_HI        = 1;
    localparam int unsigned ADDR_MAX       = 32;

    // Callers truncate to their own address width, so the linear carry out
    // of bit ADDR_WIDTH-1 is discarded and 0xFFFF wraps to 0x0000.
    function automatic logic [ADDR_MAX-1:0] next_byte_addr(
        input logic [ADDR_MAX-1:0] addr,
        input logic                pagewrap
    );
        logic [ADDR_MAX-1:0] nxt;
        if (pagewrap)
            nxt = {addr[ADDR_MAX-1:8], addr[7:0] + 8'd1};
        else
            nxt = addr + 32'd1;
        return nxt;
    endfunction

endpackage

// File: rtl/mem_requester.sv
// Initiator for one port of the dual-port system RAM: turns a valid/ready
// request into RAM cycles and returns byte or 16-bit little-endian results.
module mem_requester
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic                      req_wide,
    input  logic                      req_pagewrap,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [2*DATA_WIDTH-1:0]   req_wdata,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [2*DATA_WIDTH-1:0]   resp_rdata,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    output logic                      mem_we,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    input  logic [DATA_WIDTH-1:0]     mem_rdata
);

    localparam int unsigned WIDE_W = 2 * DATA_WIDTH;
    localparam int unsigned LO_OFS = LANE_LO * DATA_WIDTH;
    localparam int unsigned HI_OFS = LANE_HI * DATA_WIDTH;

    mem_state_t              state;
    logic [ADDR_WIDTH-1:0]   hi_addr_q;
    logic [DATA_WIDTH-1:0]   hi_wdata_q;
    logic                    we_q;
    logic                    wide_q;
    logic [ADDR_WIDTH-1:0]   hi_addr_next;

    always_comb begin
        hi_addr_next = ADDR_WIDTH'(next_byte_addr(ADDR_MAX'(req_addr),
                                                  req_pagewrap && req_wide));
    end

    assign req_ready = (state == IDLE) && !rst;

    // The lo byte goes to the RAM combinationally on the accept edge; only
    // the hi byte of a wide access comes from the latched request.
    always_comb begin
        mem_addr  = req_addr;
        mem_we    = 1'b0;
        mem_wdata = req_wdata[LO_OFS +: DATA_WIDTH];
        if (state == HI) begin
            mem_addr  = hi_addr_q;
            mem_we    = we_q;
            mem_wdata = hi_wdata_q;
        end else if (state == IDLE) begin
            mem_we = req_valid && req_ready && req_we;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            hi_addr_q  <= '0;
            hi_wdata_q <= '0;
            we_q       <= 1'b0;
            wide_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        hi_addr_q  <= hi_addr_next;
                        hi_wdata_q <= req_wdata[HI_OFS +: DATA_WIDTH];
                        we_q       <= req_we;
                        wide_q     <= req_wide;
                        if (req_we)
                            resp_rdata <= '0;
                        if (req_wide) begin
                            state <= HI;
                        end else if (req_we) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                HI: begin
                    if (we_q) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                    end else begin
                        resp_rdata[LO_OFS +: DATA_WIDTH] <= mem_rdata;
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (wide_q)
                        resp_rdata[HI_OFS +: DATA_WIDTH] <= mem_rdata;
                    else
                        resp_rdata <= WIDE_W'(mem_rdata);
                    state      <= RESP;
                    resp_valid <= 1'b1;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
